// File: rtl/vita49_trig_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : vita49_trig_sched_if
// Description : Bundle for the VITA-49 timed trigger scheduler. It carries the
//               running timestamp, the command push handshake, the cancel
//               strobe, and the event/status outputs.
//   master : drives tsi, tsf, cmd_*, cancel; observes everything else
//   slave  : the scheduler side, the mirror image of master
// Revision    : 1.0 - initial release
// ============================================================================
interface vita49_trig_sched_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [31:0]      tsi;
  logic [63:0]      tsf;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_tsi;
  logic [63:0]      cmd_tsf;
  logic [TAG_W-1:0] cmd_tag;
  logic             cancel;
  logic             trig;
  logic             late;
  logic [TAG_W-1:0] ev_tag;
  logic             armed;
  logic [LVL_W-1:0] level;
  logic [15:0]      late_cnt;

  modport master (
    output tsi, tsf, cmd_valid, cmd_tsi, cmd_tsf, cmd_tag, cancel,
    input  cmd_ready, trig, late, ev_tag, armed, level, late_cnt
  );

  modport slave (
    input  tsi, tsf, cmd_valid, cmd_tsi, cmd_tsf, cmd_tag, cancel,
    output cmd_ready, trig, late, ev_tag, armed, level, late_cnt
  );
endinterface
`default_nettype wire

// File: rtl/vita49_trig_sched.sv
`default_nettype none
// ============================================================================
// Module      : vita49_trig_sched
// Description : Timed trigger scheduler. Commands {tsi, tsf, tag} are queued
//               in a FIFO. Each command is moved into a target register and
//               compared, unsigned over 96 bits, against the running
//               timestamp. It then fires (trig), is discarded as late (late),
//               or waits in ARMED until its time arrives.
// Ports       : samp_clk - sole clock, rising edge
//               ARESETN  - asynchronous active-low reset
//               bus      - vita49_trig_sched_if.slave (timestamp, command
//                          handshake, cancel, trig/late/ev_tag, armed,
//                          level, late_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module vita49_trig_sched #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                samp_clk,
  input  logic                ARESETN,
  vita49_trig_sched_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 96 + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   count_q, count_d;
  logic [ENT_W-1:0]   tgt_q, tgt_d;
  logic               trig_q, trig_d;
  logic               late_q, late_d;
  logic [TAG_W-1:0]   ev_tag_q, ev_tag_d;
  logic [15:0]        late_cnt_q, late_cnt_d;
  logic               rdy_q;

  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic [95:0]        w_now;
  logic [95:0]        w_tgt_time;
  logic [TAG_W-1:0]   w_tgt_tag;

  // rdy_q holds cmd_ready low through reset and for the edge that ends it.
  assign w_ready    = rdy_q && (count_q < LVL_W'(DEPTH)) && !bus.cancel;
  assign w_push     = bus.cmd_valid && w_ready;
  // No pop is allowed in the cycle that carries an event pulse. Each entry
  // therefore takes IDLE -> CHECK -> event, which keeps successive pulses at
  // least three cycles apart.
  assign w_pop      = (state_q == S_IDLE) && (count_q != '0) &&
                      !trig_q && !late_q && !bus.cancel;
  assign w_now      = {bus.tsi, bus.tsf};
  assign w_tgt_time = tgt_q[ENT_W-1 -: 96];
  assign w_tgt_tag  = tgt_q[TAG_W-1:0];

  // FIFO storage carries no reset; only pointers and occupancy are reset.
  always_ff @(posedge samp_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {bus.cmd_tsi, bus.cmd_tsf, bus.cmd_tag};
    end
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    trig_d     = 1'b0;
    late_d     = 1'b0;
    ev_tag_d   = ev_tag_q;
    late_cnt_d = late_cnt_q;
    wr_ptr_d   = wr_ptr_q + PTR_W'(w_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(w_pop);
    count_d    = count_q + LVL_W'(w_push) - LVL_W'(w_pop);

    unique case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          tgt_d   = mem_q[rd_ptr_q];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_tgt_time < w_now) begin
          late_d   = 1'b1;
          ev_tag_d = w_tgt_tag;
          if (late_cnt_q != 16'hFFFF) begin
            late_cnt_d = late_cnt_q + 16'd1;
          end
          state_d  = S_IDLE;
        end else if (w_tgt_time == w_now) begin
          trig_d   = 1'b1;
          ev_tag_d = w_tgt_tag;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_now >= w_tgt_time) begin
          trig_d   = 1'b1;
          ev_tag_d = w_tgt_tag;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // cancel wins over everything: flush, disarm, drop any pending event.
    // The late counter and the last reported tag are kept.
    if (bus.cancel) begin
      state_d    = S_IDLE;
      trig_d     = 1'b0;
      late_d     = 1'b0;
      ev_tag_d   = ev_tag_q;
      late_cnt_d = late_cnt_q;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge samp_clk or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      trig_q     <= 1'b0;
      late_q     <= 1'b0;
      ev_tag_q   <= '0;
      late_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      trig_q     <= trig_d;
      late_q     <= late_d;
      ev_tag_q   <= ev_tag_d;
      late_cnt_q <= late_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdy_q      <= 1'b1;
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.trig      = trig_q;
  assign bus.late      = late_q;
  assign bus.ev_tag    = ev_tag_q;
  assign bus.armed     = (state_q == S_ARMED);
  assign bus.level     = count_q;
  assign bus.late_cnt  = late_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vita49_trig_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_vita49_trig_sched
// Description : Directed bench for vita49_trig_sched (DEPTH=4, TAG_W=8).
//               Inputs change 1 ns after the rising edge; outputs are
//               sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vita49_trig_sched;

  localparam int DEPTH = 4;
  localparam int TAG_W = 8;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  bit   run_tsf = 1'b0;
  int   passed  = 0;
  int   total   = 0;

  vita49_trig_sched_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  vita49_trig_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .samp_clk (clk),
    .ARESETN  (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: edge, settle, then advance the running fractional time.
  task automatic tick();
    @(posedge clk);
    #1;
    if (run_tsf) bus.tsf = bus.tsf + 64'd1;
  endtask

  task automatic offer(input logic [31:0] t_i, input logic [63:0] t_f, input logic [7:0] tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_tsi   = t_i;
    bus.cmd_tsf   = t_f;
    bus.cmd_tag   = tag;
  endtask

  initial begin
    logic [63:0] samp;
    int          seen;
    int          nlate;
    int          ev_n;
    logic [7:0]  ev_tag_l [3];
    bit          ev_late_l [3];
    logic [63:0] ev_ts_l [3];

    bus.tsi = 32'd0; bus.tsf = 64'd0;
    bus.cmd_valid = 1'b0; bus.cmd_tsi = 32'd0; bus.cmd_tsf = 64'd0;
    bus.cmd_tag = 8'd0; bus.cancel = 1'b0;

    // ---------------- reset ----------------
    tick(); tick();
    chk("rst_ready",    64'(bus.cmd_ready), 64'd0);
    chk("rst_trig",     64'(bus.trig),      64'd0);
    chk("rst_late",     64'(bus.late),      64'd0);
    chk("rst_armed",    64'(bus.armed),     64'd0);
    chk("rst_level",    64'(bus.level),     64'd0);
    chk("rst_late_cnt", 64'(bus.late_cnt),  64'd0);
    rst_n = 1'b1;
    chk("ready_before_edge", 64'(bus.cmd_ready), 64'd0);
    tick();
    chk("ready_after_edge",  64'(bus.cmd_ready), 64'd1);

    // ---------------- future target fires once ----------------
    bus.tsi = 32'd5; bus.tsf = 64'd0;
    offer(32'd5, 64'd100, 8'h11);
    tick();
    bus.cmd_valid = 1'b0;
    chk("a_level_push", 64'(bus.level), 64'd1);
    tick();
    chk("a_level_pop",  64'(bus.level), 64'd0);
    chk("a_not_armed",  64'(bus.armed), 64'd0);
    tick();
    chk("a_armed",      64'(bus.armed), 64'd1);
    run_tsf = 1'b1;
    seen = 0; nlate = 0; samp = 64'd0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      samp = bus.tsf;
      tick();
      if (bus.late) nlate++;
      if (bus.trig) seen = 1;
    end
    chk("a_trig_seen",   64'(seen),        64'd1);
    chk("a_trig_time",   samp,             64'd100);
    chk("a_ev_tag",      64'(bus.ev_tag),  64'h11);
    chk("a_armed_drop",  64'(bus.armed),   64'd0);
    chk("a_no_late",     64'(nlate),       64'd0);
    run_tsf = 1'b0;
    tick();
    chk("a_trig_once",   64'(bus.trig),    64'd0);

    // ---------------- past targets, simultaneous push/pop, spacing ----------------
    bus.tsi = 32'd5; bus.tsf = 64'd200;
    offer(32'd5, 64'd100, 8'h22);
    tick();
    offer(32'd5, 64'd150, 8'h23);
    chk("b_ready",       64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("b_simul_level", 64'(bus.level),    64'd1);
    chk("b_late_early",  64'(bus.late),     64'd0);
    tick();
    chk("b_late1",       64'(bus.late),     64'd1);
    chk("b_late1_tag",   64'(bus.ev_tag),   64'h22);
    chk("b_late1_cnt",   64'(bus.late_cnt), 64'd1);
    chk("b_late1_trig",  64'(bus.trig),     64'd0);
    tick();
    chk("b_gap1_late",   64'(bus.late),     64'd0);
    chk("b_gap1_level",  64'(bus.level),    64'd1);
    tick();
    chk("b_gap2_late",   64'(bus.late),     64'd0);
    chk("b_gap2_level",  64'(bus.level),    64'd0);
    tick();
    chk("b_late2",       64'(bus.late),     64'd1);
    chk("b_late2_tag",   64'(bus.ev_tag),   64'h23);
    chk("b_late2_cnt",   64'(bus.late_cnt), 64'd2);
    chk("b_late2_trig",  64'(bus.trig),     64'd0);

    // ---------------- full queue while armed ----------------
    bus.tsf = 64'd0;
    tick();
    offer(32'd5, 64'd50, 8'h30);
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick();
    chk("c_armed",       64'(bus.armed), 64'd1);
    for (int i = 0; i < 4; i++) begin
      offer(32'd6, 64'd0, 8'(8'h31 + i));
      tick();
    end
    offer(32'd6, 64'd0, 8'h35);
    chk("c_full_ready",  64'(bus.cmd_ready), 64'd0);
    chk("c_full_level",  64'(bus.level),     64'd4);
    tick();
    chk("c_hold_level",  64'(bus.level),     64'd4);
    bus.tsf = 64'd50;
    tick();
    chk("c_fire_trig",   64'(bus.trig),      64'd1);
    chk("c_fire_tag",    64'(bus.ev_tag),    64'h30);
    chk("c_fire_armed",  64'(bus.armed),     64'd0);
    chk("c_fire_level",  64'(bus.level),     64'd4);
    tick();
    chk("c_after_trig",  64'(bus.trig),      64'd0);
    tick();
    chk("c_pop_level",   64'(bus.level),     64'd3);
    chk("c_pop_ready",   64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("c_refill_level", 64'(bus.level),    64'd4);
    chk("c_rearmed",     64'(bus.armed),     64'd1);

    // ---------------- cancel ----------------
    bus.cancel = 1'b1;
    offer(32'd7, 64'd0, 8'h66);
    chk("d_ready_cancel", 64'(bus.cmd_ready), 64'd0);
    tick();
    bus.cancel = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("d_level",       64'(bus.level), 64'd0);
    chk("d_armed",       64'(bus.armed), 64'd0);
    bus.tsi = 32'd7;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.trig || bus.late) seen++;
    end
    chk("d_no_events",   64'(seen),         64'd0);
    chk("d_late_cnt",    64'(bus.late_cnt), 64'd2);

    // ---------------- ordering ----------------
    bus.tsi = 32'd5; bus.tsf = 64'd100; run_tsf = 1'b1;
    offer(32'd5, 64'd300, 8'hA1); tick();
    offer(32'd5, 64'd200, 8'hB2); tick();
    offer(32'd5, 64'd400, 8'hC3); tick();
    bus.cmd_valid = 1'b0;
    ev_n = 0;
    for (int i = 0; i < 3; i++) begin
      ev_tag_l[i] = 8'h00; ev_late_l[i] = 1'b0; ev_ts_l[i] = 64'd0;
    end
    for (int i = 0; i < 600 && ev_n < 3; i++) begin
      samp = bus.tsf;
      tick();
      if (bus.trig || bus.late) begin
        ev_tag_l[ev_n]  = bus.ev_tag;
        ev_late_l[ev_n] = bus.late;
        ev_ts_l[ev_n]   = samp;
        ev_n++;
      end
    end
    run_tsf = 1'b0;
    chk("e_count",    64'(ev_n),         64'd3);
    chk("e_a_tag",    64'(ev_tag_l[0]),  64'hA1);
    chk("e_a_trig",   64'(ev_late_l[0]), 64'd0);
    chk("e_a_time",   ev_ts_l[0],        64'd300);
    chk("e_b_tag",    64'(ev_tag_l[1]),  64'hB2);
    chk("e_b_late",   64'(ev_late_l[1]), 64'd1);
    chk("e_c_tag",    64'(ev_tag_l[2]),  64'hC3);
    chk("e_c_trig",   64'(ev_late_l[2]), 64'd0);
    chk("e_c_time",   ev_ts_l[2],        64'd400);
    chk("e_late_cnt", 64'(bus.late_cnt), 64'd3);

    // ---------------- reset while armed ----------------
    bus.tsf = 64'd0;
    tick();
    offer(32'd5, 64'd100, 8'h44); tick();
    offer(32'd5, 64'd120, 8'h45); tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("f_armed_pre",  64'(bus.armed), 64'd1);
    chk("f_level_pre",  64'(bus.level), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("f_armed",      64'(bus.armed),     64'd0);
    chk("f_level",      64'(bus.level),     64'd0);
    chk("f_ready",      64'(bus.cmd_ready), 64'd0);
    chk("f_late_cnt",   64'(bus.late_cnt),  64'd0);
    chk("f_ev_tag",     64'(bus.ev_tag),    64'd0);
    chk("f_trig",       64'(bus.trig),      64'd0);
    chk("f_late",       64'(bus.late),      64'd0);
    tick();
    rst_n = 1'b1;
    bus.tsf = 64'd200;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.trig || bus.late) seen++;
    end
    chk("f_no_events",  64'(seen),          64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
